// File: rtl/alu_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_arb_pkg
//  Description : Shared definitions for the ALU request arbiter.
//                - OP_W / MOVI_W : widths of the op code and operand-B select.
//                - alu_op_t      : one ALU operation as seen by the ALU port.
//                - rr_pick()     : round-robin winner search (up to 8 requesters).
//  Revision    : 1.0  initial release
// ============================================================================
package alu_arb_pkg;

    localparam int OP_W   = 4;
    localparam int MOVI_W = 2;
    localparam int ALU_DW = 8;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [MOVI_W-1:0] movi;
        logic [ALU_DW-1:0] reg_a;
        logic [ALU_DW-1:0] reg_b;
        logic [ALU_DW-1:0] mem;
        logic [ALU_DW-1:0] imm;
    } alu_op_t;

    // First set bit of vld at or after ptr, wrapping n-1 -> 0. Only the low
    // n bits of vld are considered. Returns 0 when nothing is set; callers
    // qualify the result with |vld. n is a constant at every call site, so
    // the loop flattens into a fixed priority mux.
    function automatic logic [2:0] rr_pick(input logic [7:0]  vld,
                                           input logic [2:0]  ptr,
                                           input int unsigned n);
        logic [2:0]  win;
        logic        found;
        int unsigned idx;
        win   = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < 8; k++) begin
            idx = 32'(ptr) + k;
            if (idx >= n) begin
                idx = idx - n;
            end
            if ((k < n) && !found && vld[idx[2:0]]) begin
                win   = idx[2:0];
                found = 1'b1;
            end
        end
        return win;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_arb_tag_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : alu_arb_tag_fifo
//  Description : In-order tag FIFO holding the issuer index of every op in
//                flight. A pop on an empty FIFO is ignored; a push while full
//                is accepted only together with a pop (pop-then-push).
//  Ports       : clk, rst_n (async, active-low)
//                push/din  - enqueue a tag
//                pop       - dequeue the head tag
//                dout      - head tag
//                full/empty/count - occupancy
//  Revision    : 1.0  initial release
// ============================================================================
module alu_arb_tag_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    push,
    input  logic [WIDTH-1:0]        din,
    input  logic                    pop,
    output logic [WIDTH-1:0]        dout,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr;
    logic [PTR_W-1:0] r_rd;
    logic [CNT_W-1:0] r_cnt;
    logic             w_do_push;
    logic             w_do_pop;

    assign empty     = (r_cnt == '0);
    assign full      = (r_cnt == C_DEPTH);
    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | w_do_pop);
    assign dout      = r_mem[r_rd];
    assign count     = r_cnt;

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_do_push) begin
                r_wr <= r_wr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd <= r_rd + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_cnt <= r_cnt + CNT_W'(1);
                2'b01:   r_cnt <= r_cnt - CNT_W'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr] <= din;
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_req_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : alu_req_arbiter
//  Description : Shares one in-order ALU between NUM_REQ requesters.
//                Round-robin grant (one op per cycle while alu_rdy), registered
//                op fields towards the ALU, and a tag FIFO that routes every
//                result back to the requester that issued it.
//  Config      : `define ALU_ARB_PRIO_EN -> requester 0 has fixed top priority
//                and does not move the RR pointer; 1..NUM_REQ-1 share RR.
//  Ports       : clk, rst_n (async, active-low)
//                req_vld/op/movi/a/b/mem/imm - packed per-requester op, slice i
//                req_gnt    - one-hot accept, combinational, cycle of issue
//                alu_act/op/movi/reg_a/reg_b/mem/imm - registered op to ALU
//                alu_rdy    - ALU can accept an op this cycle
//                ex_alu/ex_alu_vld - in-order ALU result
//                res_data/res_vld  - registered result + one-hot owner
//                outst_cnt  - ops in flight;  err - sticky spurious result
//  Revision    : 1.0  initial release
// ============================================================================
module alu_req_arbiter
    import alu_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4,
    parameter int MAX_OUTST  = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             req_vld,
    input  logic [NUM_REQ*OP_W-1:0]        req_op,
    input  logic [NUM_REQ*MOVI_W-1:0]      req_movi,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_a,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_b,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_mem,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_imm,
    output logic [NUM_REQ-1:0]             req_gnt,
    output logic                           alu_act,
    output logic [OP_W-1:0]                alu_op,
    output logic [MOVI_W-1:0]              alu_movi,
    output logic [DATA_WIDTH-1:0]          alu_reg_a,
    output logic [DATA_WIDTH-1:0]          alu_reg_b,
    output logic [DATA_WIDTH-1:0]          alu_mem,
    output logic [DATA_WIDTH-1:0]          alu_imm,
    input  logic                           alu_rdy,
    input  logic [DATA_WIDTH-1:0]          ex_alu,
    input  logic                           ex_alu_vld,
    output logic [DATA_WIDTH-1:0]          res_data,
    output logic [NUM_REQ-1:0]             res_vld,
    output logic [$clog2(MAX_OUTST):0]     outst_cnt,
    output logic                           err
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam logic [IDX_W-1:0] C_LAST = IDX_W'(NUM_REQ - 1);

    logic [IDX_W-1:0]      r_ptr;
    logic [IDX_W-1:0]      w_win;
    logic [IDX_W-1:0]      w_ptr_nxt;
    logic [NUM_REQ-1:0]    w_rr_vld;
    logic                  w_issue;
    logic                  w_full;
    logic                  w_empty;
    logic [IDX_W-1:0]      w_head;

    logic                  r_alu_act;
    logic [OP_W-1:0]       r_alu_op;
    logic [MOVI_W-1:0]     r_alu_movi;
    logic [DATA_WIDTH-1:0] r_alu_a;
    logic [DATA_WIDTH-1:0] r_alu_b;
    logic [DATA_WIDTH-1:0] r_alu_mem;
    logic [DATA_WIDTH-1:0] r_alu_imm;
    logic [DATA_WIDTH-1:0] r_res_data;
    logic [NUM_REQ-1:0]    r_res_vld;
    logic                  r_err;

    // Winner selection and the pointer value to load if this winner issues.
    always_comb begin
        w_rr_vld = req_vld;
`ifdef ALU_ARB_PRIO_EN
        w_rr_vld[0] = 1'b0;
`endif
        w_win     = IDX_W'(rr_pick(8'(w_rr_vld), 3'(r_ptr), NUM_REQ));
`ifdef ALU_ARB_PRIO_EN
        if (req_vld[0]) begin
            w_win = '0;
        end
`endif
        w_ptr_nxt = (w_win == C_LAST) ? '0 : (w_win + IDX_W'(1));
`ifdef ALU_ARB_PRIO_EN
        if (req_vld[0]) begin
            w_ptr_nxt = r_ptr;
        end
`endif
    end

    // A full FIFO may still issue when a result retires in the same cycle.
    assign w_issue = alu_rdy & (|req_vld) & (~w_full | ex_alu_vld);

    // Gated with rst_n so the grant drops the moment reset is asserted.
    always_comb begin
        req_gnt = '0;
        if (w_issue && rst_n) begin
            req_gnt[w_win] = 1'b1;
        end
    end

    alu_arb_tag_fifo #(
        .WIDTH (IDX_W),
        .DEPTH (MAX_OUTST)
    ) u_tag_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_issue),
        .din   (w_win),
        .pop   (ex_alu_vld),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty),
        .count (outst_cnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr      <= '0;
            r_alu_act  <= 1'b0;
            r_alu_op   <= '0;
            r_alu_movi <= '0;
            r_alu_a    <= '0;
            r_alu_b    <= '0;
            r_alu_mem  <= '0;
            r_alu_imm  <= '0;
            r_res_data <= '0;
            r_res_vld  <= '0;
            r_err      <= 1'b0;
        end else begin
            r_alu_act <= w_issue;
            if (w_issue) begin
                r_ptr      <= w_ptr_nxt;
                r_alu_op   <= req_op[w_win*OP_W +: OP_W];
                r_alu_movi <= req_movi[w_win*MOVI_W +: MOVI_W];
                r_alu_a    <= req_a[w_win*DATA_WIDTH +: DATA_WIDTH];
                r_alu_b    <= req_b[w_win*DATA_WIDTH +: DATA_WIDTH];
                r_alu_mem  <= req_mem[w_win*DATA_WIDTH +: DATA_WIDTH];
                r_alu_imm  <= req_imm[w_win*DATA_WIDTH +: DATA_WIDTH];
            end
            r_res_vld <= '0;
            if (ex_alu_vld) begin
                // A result with nothing in flight has no owner: flag it only.
                if (w_empty) begin
                    r_err <= 1'b1;
                end else begin
                    r_res_vld[w_head] <= 1'b1;
                    r_res_data        <= ex_alu;
                end
            end
        end
    end

    assign alu_act   = r_alu_act;
    assign alu_op    = r_alu_op;
    assign alu_movi  = r_alu_movi;
    assign alu_reg_a = r_alu_a;
    assign alu_reg_b = r_alu_b;
    assign alu_mem   = r_alu_mem;
    assign alu_imm   = r_alu_imm;
    assign res_data  = r_res_data;
    assign res_vld   = r_res_vld;
    assign err       = r_err;

endmodule
`default_nettype wire
